// File: rtl/arm_ctl_pkg.sv
// Shared encodings for the multi-cycle ARM control unit: FSM states, datapath
// select constants, condition and command encodings.
package arm_ctl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
    StMemWr, StExecR, StExecI, StAluWb, StBranch
  } state_e;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  localparam logic [1:0] ImmSrc8  = 2'b00;
  localparam logic [1:0] ImmSrc12 = 2'b01;
  localparam logic [1:0] ImmSrc24 = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdOrr = 4'b1100;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctl;
    logic       pc_src;
  } ctl_t;

  localparam ctl_t CtlFetch = '{
    pc_write:   1'b1,
    adr_src:    1'b0,
    mem_write:  1'b0,
    ir_write:   1'b1,
    reg_write:  1'b0,
    result_src: ResAluResult,
    alu_src_a:  1'b1,
    alu_src_b:  SrcBFour,
    alu_ctl:    AluAdd,
    pc_src:     1'b0
  };

  typedef struct packed {
    logic       ok;
    logic [1:0] ctl;
  } alu_dec_t;

  // Unsupported commands decode as ADD with ok=0 so writeback and flags are suppressed.
  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    d.ok  = 1'b1;
    d.ctl = AluAdd;
    case (cmd)
      CmdAdd:  d.ctl = AluAdd;
      CmdSub:  d.ctl = AluSub;
      CmdAnd:  d.ctl = AluAnd;
      CmdOrr:  d.ctl = AluOrr;
      default: d.ok  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flag register with split N/Z and C/V write enables, plus combinational
// evaluation of the instruction condition field against the stored flags.
module cond_logic
  import arm_ctl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       nz_we_i,
  input  logic       cv_we_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (nz_we_i) flags_d[3:2] = alu_flags_i[3:2];
    if (cv_we_i) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  always_comb begin
    cond_ex_o = 1'b0;
    unique case (cond_i)
      CondEq:  cond_ex_o = z;
      CondNe:  cond_ex_o = ~z;
      CondCs:  cond_ex_o = c;
      CondCc:  cond_ex_o = ~c;
      CondMi:  cond_ex_o = n;
      CondPl:  cond_ex_o = ~n;
      CondVs:  cond_ex_o = v;
      CondVc:  cond_ex_o = ~v;
      CondHi:  cond_ex_o = c & ~z;
      CondLs:  cond_ex_o = ~c | z;
      CondGe:  cond_ex_o = (n == v);
      CondLt:  cond_ex_o = (n != v);
      CondGt:  cond_ex_o = ~z & (n == v);
      CondLe:  cond_ex_o = z | (n != v);
      CondAl:  cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle ARM control unit: instruction decode, 10-state sequencing FSM with
// registered Moore outputs, and the cond_ex latch feeding write strobes.
module multi_cycle_controller
  import arm_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] instr,
  input  logic [3:0]  alu_flags,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_ctl,
  output logic [1:0]  imm_src,
  output logic        pc_src
);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit, rd_pc, unused_rn;

  assign cond      = instr[19:16];
  assign op        = instr[15:14];
  assign i_bit     = instr[13];
  assign cmd       = instr[12:9];
  assign s_bit     = instr[8];
  assign rd        = instr[3:0];
  assign rd_pc     = (rd == 4'hf);
  assign unused_rn = ^instr[7:4];

  state_e   state_q, state_d;
  ctl_t     ctl_q, ctl_d;
  alu_dec_t dec;
  logic     cond_ex, cond_ex_q, cond_ex_d, flag_we;

  assign dec = alu_decode(cmd);

  // Flags are written by the EXEC cycle itself, gated by the latched condition.
  assign flag_we = (state_q inside {StExecR, StExecI}) & s_bit & cond_ex_q & dec.ok;

  cond_logic u_cond (
    .clk_i       (clk),
    .rst_i       (reset),
    .cond_i      (cond),
    .alu_flags_i (alu_flags),
    .nz_we_i     (flag_we),
    .cv_we_i     (flag_we & ~dec.ctl[1]),
    .cond_ex_o   (cond_ex)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (op)
          2'b00:   state_d = i_bit ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr:         state_d = s_bit ? StMemRd : StMemWr;
      StMemRd:          state_d = StMemWb;
      StExecR, StExecI: state_d = StAluWb;
      default:          state_d = StFetch;
    endcase
  end

  // BRANCH is entered straight from DECODE, so it needs the value being latched now.
  assign cond_ex_d = (state_q == StDecode) ? cond_ex : cond_ex_q;

  always_comb begin
    ctl_d = '0;
    unique case (state_d)
      StFetch:  ctl_d = CtlFetch;
      StDecode: begin
        ctl_d.alu_src_a  = 1'b1;
        ctl_d.alu_src_b  = SrcBFour;
        ctl_d.result_src = ResAluResult;
      end
      StMemAdr: ctl_d.alu_src_b = SrcBImm;
      StMemRd:  ctl_d.adr_src = 1'b1;
      StMemWb:  begin
        ctl_d.result_src = ResReadData;
        ctl_d.reg_write  = cond_ex_d;
        ctl_d.pc_src     = rd_pc;
        ctl_d.pc_write   = cond_ex_d & rd_pc;
      end
      StMemWr:  begin
        ctl_d.adr_src   = 1'b1;
        ctl_d.mem_write = cond_ex_d;
      end
      StExecR:  begin
        ctl_d.alu_src_b = SrcBReg;
        ctl_d.alu_ctl   = dec.ctl;
      end
      StExecI:  begin
        ctl_d.alu_src_b = SrcBImm;
        ctl_d.alu_ctl   = dec.ctl;
      end
      StAluWb:  begin
        ctl_d.result_src = ResAluOut;
        ctl_d.reg_write  = cond_ex_d & dec.ok;
        ctl_d.pc_src     = rd_pc;
        ctl_d.pc_write   = cond_ex_d & dec.ok & rd_pc;
      end
      StBranch: begin
        ctl_d.alu_src_b  = SrcBImm;
        ctl_d.result_src = ResAluResult;
        ctl_d.pc_write   = cond_ex_d;
      end
      default:  ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      cond_ex_q <= 1'b0;
      ctl_q     <= CtlFetch;
    end else begin
      state_q   <= state_d;
      cond_ex_q <= cond_ex_d;
      ctl_q     <= ctl_d;
    end
  end

  always_comb begin
    imm_src = ImmSrc8;
    unique case (op)
      2'b01:   imm_src = ImmSrc12;
      2'b10:   imm_src = ImmSrc24;
      default: imm_src = ImmSrc8;
    endcase
  end

  assign pc_write   = ctl_q.pc_write;
  assign adr_src    = ctl_q.adr_src;
  assign mem_write  = ctl_q.mem_write;
  assign ir_write   = ctl_q.ir_write;
  assign reg_write  = ctl_q.reg_write;
  assign result_src = ctl_q.result_src;
  assign alu_src_a  = ctl_q.alu_src_a;
  assign alu_src_b  = ctl_q.alu_src_b;
  assign alu_ctl    = ctl_q.alu_ctl;
  assign pc_src     = ctl_q.pc_src;

endmodule
